// File: rtl/alu_sweep_sequencer_pkg.sv
// Shared types and default sizes for the ALU sweep sequencer.
// Holds the FSM state encoding and the opcode type used by the sequencer and its stream interface.
package alu_seq_pkg;

    localparam int unsigned Width = 32;
    localparam int unsigned Opw   = 3;
    localparam int unsigned NOps  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StPresent
    } state_e;

    typedef logic [Opw-1:0] opcode_t;

endpackage

// File: rtl/alu_sweep_sequencer_if.sv
// Valid/ready result stream carrying one ALU result tagged with its opcode.
// The producer (sequencer) uses master; the consumer uses slave.
interface alu_sweep_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = Width,
    parameter int unsigned OPW   = Opw
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic [OPW-1:0]   opcode;
    logic             last;

    modport master (
        output valid,
        output data,
        output opcode,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  opcode,
        input  last,
        output ready
    );

endinterface

// File: rtl/alu_sweep_sequencer.sv
// Latches an operand pair on start, steps the ALU opcode through 0..N_OPS-1 and streams each
// registered result out with valid/ready backpressure; pulses done after the last handshake.
module alu_sweep_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = Width,
    parameter int unsigned OPW   = Opw,
    parameter int unsigned N_OPS = NOps
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      start_a,
    input  logic [WIDTH-1:0]      start_b,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [OPW-1:0]        alu_opcode,
    output logic                  alu_en,
    input  logic [WIDTH-1:0]      alu_result,
    alu_sweep_sequencer_if.master res
);

    localparam logic [OPW-1:0] LastOp = OPW'(N_OPS - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   opcode_q, opcode_d;
    logic             alu_en_q, alu_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [OPW-1:0]   res_opcode_q, res_opcode_d;
    logic             res_last_q, res_last_d;
    logic             handshake;

    assign handshake = res_valid_q && res.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StDrive;
            StDrive:   state_d = StPresent;
            StPresent: if (handshake) state_d = res_last_q ? StIdle : StDrive;
            default:   state_d = StIdle;
        endcase
    end

    // Everything holds by default, so backpressure in StPresent freezes both ALU and stream sides.
    always_comb begin
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        opcode_d     = opcode_q;
        alu_en_d     = alu_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_opcode_d = res_opcode_q;
        res_last_d   = res_last_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    alu_a_d  = start_a;
                    alu_b_d  = start_b;
                    opcode_d = '0;
                    alu_en_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            StDrive: begin
                res_data_d   = alu_result;
                res_opcode_d = opcode_q;
                res_last_d   = (opcode_q == LastOp);
                res_valid_d  = 1'b1;
            end
            StPresent: begin
                if (handshake) begin
                    res_valid_d = 1'b0;
                    if (res_last_q) begin
                        alu_en_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        opcode_d = opcode_q + OPW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            opcode_q     <= '0;
            alu_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_opcode_q <= '0;
            res_last_q   <= 1'b0;
        end else begin
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            opcode_q     <= opcode_d;
            alu_en_q     <= alu_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_opcode_q <= res_opcode_d;
            res_last_q   <= res_last_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = opcode_q;
    assign alu_en     = alu_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign res.valid  = res_valid_q;
    assign res.data   = res_data_q;
    assign res.opcode = res_opcode_q;
    assign res.last   = res_last_q;

endmodule

// File: tb/tb_alu_sweep_sequencer.sv
// Randomized self-checking bench for alu_sweep_sequencer; expected results come from the
// sweep rule (result k = a + b + k) and cycle counts from 2*N_OPS plus stall cycles.
module tb_alu_sweep_sequencer;
    import alu_seq_pkg::*;

    localparam int NOPS = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] start_a, start_b;
    logic        busy, done, alu_en;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_opcode;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sweep_sequencer_if #(.WIDTH(32), .OPW(3)) res_if ();

    alu_sweep_sequencer #(.WIDTH(32), .OPW(3), .N_OPS(NOPS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_a    (start_a),
        .start_b    (start_b),
        .busy       (busy),
        .done       (done),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_en     (alu_en),
        .alu_result (alu_result),
        .res        (res_if)
    );

    // Behavioural ALU standing in for alu32bit.
    function automatic logic [31:0] alu_model_tb(input logic en, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [2:0] op);
        return en ? (a + b + 32'(op)) : 32'h0;
    endfunction

    assign alu_result = alu_model_tb(alu_en, alu_a, alu_b, alu_opcode);

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string when);
        check_eq({when, "_busy"}, 32'(busy), 0);
        check_eq({when, "_done"}, 32'(done), 0);
        check_eq({when, "_alu_en"}, 32'(alu_en), 0);
        check_eq({when, "_alu_a"}, alu_a, 0);
        check_eq({when, "_alu_b"}, alu_b, 0);
        check_eq({when, "_alu_opcode"}, 32'(alu_opcode), 0);
        check_eq({when, "_res_valid"}, 32'(res_if.valid), 0);
        check_eq({when, "_res_data"}, res_if.data, 0);
        check_eq({when, "_res_opcode"}, 32'(res_if.opcode), 0);
        check_eq({when, "_res_last"}, 32'(res_if.last), 0);
    endtask

    // Runs one sweep; returns in the cycle where done is high so a caller may chain a start.
    task automatic run_sweep(input logic [31:0] a, input logic [31:0] b, input int stall_idx,
                             input int stall_n, input bit rand_ready, input bit mid_start);
        int cyc    = 0;
        int idx    = 0;
        int stalls = 0;
        bit prev_stall = 1'b0;
        bit finished   = 1'b0;
        start_a = a;
        start_b = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!finished) begin
            if (done) begin
                finished = 1'b1;
                check_eq("done_latency", 32'(cyc), 32'(2 * NOPS + stalls));
                check_eq("result_count", 32'(idx), 32'(NOPS));
                check_eq("busy_at_done", 32'(busy), 0);
                check_eq("valid_at_done", 32'(res_if.valid), 0);
                start = 1'b0;
            end else if (cyc > 400) begin
                finished = 1'b1;
                check_eq("sweep_timeout", 32'(cyc), 32'(2 * NOPS + stalls));
            end else begin
                check_eq("busy_in_sweep", 32'(busy), 1);
                check_eq("alu_a_held", alu_a, a);
                check_eq("alu_b_held", alu_b, b);
                if (prev_stall) check_eq("valid_held", 32'(res_if.valid), 1);
                prev_stall = 1'b0;
                if (mid_start) begin
                    start   = (cyc == 5);
                    start_a = (cyc == 5) ? 32'h1 : a;
                end
                if (res_if.valid) begin
                    bit stall;
                    stall = rand_ready ? ($urandom_range(0, 2) == 0)
                                       : (idx == stall_idx && stalls < stall_n);
                    check_eq("res_data", res_if.data, a + b + 32'(idx));
                    if (stall) begin
                        res_if.ready = 1'b0;
                        stalls++;
                        prev_stall = 1'b1;
                    end else begin
                        res_if.ready = 1'b1;
                        check_eq("res_opcode", 32'(res_if.opcode), 32'(idx));
                        check_eq("res_last", 32'(res_if.last), 32'(idx == NOPS - 1));
                        idx++;
                    end
                end else begin
                    res_if.ready = 1'b1;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        start_a      = '0;
        start_b      = '0;
        res_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic sweep, then a stall of 3 cycles on opcode 2, then an ignored mid-sweep start.
        run_sweep(32'hFF, 32'h0F, -1, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", 32'(done), 0);
        run_sweep(32'hFF, 32'h0F, 2, 3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        run_sweep(32'hFF, 32'h0F, -1, 0, 1'b0, 1'b1);

        // Back-to-back starts issued in the done cycle.
        run_sweep(32'h1, 32'h1, -1, 0, 1'b0, 1'b0);
        run_sweep(32'hFF, 32'h0F, -1, 0, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check_eq("idle_done", 32'(done), 0);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_alu_en", 32'(alu_en), 0);
        check_eq("idle_alu_a", alu_a, 32'hFF);
        check_eq("idle_alu_b", alu_b, 32'h0F);
        check_eq("idle_res_valid", 32'(res_if.valid), 0);

        for (int i = 0; i < 6; i++) begin
            run_sweep($urandom, $urandom, -1, 0, 1'b1, 1'(i % 2));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;

        // Reset while in DRIVE: outputs clear immediately and no done follows.
        start_a = 32'hFF;
        start_b = 32'h0F;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("post_reset_done", 32'(done), 0);
            check_eq("post_reset_busy", 32'(busy), 0);
            check_eq("post_reset_valid", 32'(res_if.valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
